// File: rtl/pg68k_bus_pkg.sv
// pg68k_bus_pkg: shared 68030 bus encodings for DSACK port sizes and terminator states
package pg68k_bus_pkg;
  localparam logic [1:0] PORT_NONE = 2'b00;
  localparam logic [1:0] PORT_1 = 2'b01;
  localparam logic [1:0] PORT_2 = 2'b10;
  localparam logic [1:0] PORT_4 = 2'b11;
  typedef enum logic [1:0] {BT_IDLE, BT_WAIT, BT_ACK} bt_state_t;
endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: raises BERR after BERR_CYCLES consecutive edges with /AS low
module bus_watchdog #(
  parameter int BERR_CYCLES = 64
) (
  input  logic CPU_CLK,
  input  logic RESET,
  input  logic nAS,
  output logic BERR
);
  localparam int WD_W = $clog2(BERR_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(BERR_CYCLES - 1);
  logic [WD_W-1:0] wd;
  always_ff @(posedge CPU_CLK) begin
    if (RESET || nAS) begin
      wd <= '0;
      BERR <= 1'b0;
    end else begin
      wd <= (wd == WD_MAX) ? wd : wd + WD_W'(1);
      BERR <= (wd == WD_MAX);
    end
  end
endmodule

// File: rtl/bus_term.sv
// bus_term: DSACK generator for non-native chip-select channels plus bus-error watchdog
module bus_term
  import pg68k_bus_pkg::*;
#(
  parameter int NCHAN = 4,
  parameter int WS_W = 4,
  parameter logic [NCHAN*WS_W-1:0] WAITS = {NCHAN{4'd1}},
  parameter logic [NCHAN*2-1:0] PORTSZ = {NCHAN{2'b10}},
  parameter int BERR_CYCLES = 64
) (
  input  logic             CPU_CLK,
  input  logic             RESET,
  input  logic             nAS,
  input  logic             nDS,
  input  logic [NCHAN-1:0] nSEL,
  input  logic [NCHAN-1:0] nWAIT,
  output logic [1:0]       DSACK,
  output logic             BERR,
  output logic             BUSY,
  output logic [2:0]       ACT_CH
);
  bt_state_t state, state_n;
  logic [WS_W-1:0] cnt, cnt_n, sel_ws;
  logic [2:0] ch, ch_n, sel_idx;
  logic [1:0] dsack_r, dsack_n, cur_ps;
  logic hit, cur_rdy;
  // descending scan so the lowest enabled index is the last one written
  always_comb begin
    hit = 1'b0;
    sel_idx = '0;
    sel_ws = '0;
    cur_ps = PORT_NONE;
    cur_rdy = 1'b1;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (!nSEL[i] && PORTSZ[2*i +: 2] != PORT_NONE) begin
        hit = 1'b1;
        sel_idx = 3'(i);
        sel_ws = WAITS[WS_W*i +: WS_W];
      end
      if (ch == 3'(i)) begin
        cur_ps = PORTSZ[2*i +: 2];
        cur_rdy = nWAIT[i];
      end
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ch_n = ch;
    dsack_n = dsack_r;
    case (state)
      BT_IDLE: if (!nAS && hit) begin
        state_n = BT_WAIT;
        ch_n = sel_idx;
        cnt_n = sel_ws;
      end
      BT_WAIT: if (nAS) begin
        state_n = BT_IDLE;
        ch_n = '0;
      end else if (cnt != '0) begin
        cnt_n = cnt - WS_W'(1);
      end else if (cur_rdy) begin
        dsack_n = cur_ps;
        state_n = BT_ACK;
      end
      BT_ACK: if (nAS && nDS) begin
        dsack_n = PORT_NONE;
        state_n = BT_IDLE;
        ch_n = '0;
      end
      default: state_n = BT_IDLE;
    endcase
  end
  always_ff @(posedge CPU_CLK) begin
    if (RESET) begin
      state <= BT_IDLE;
      cnt <= '0;
      ch <= '0;
      dsack_r <= PORT_NONE;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ch <= ch_n;
      dsack_r <= dsack_n;
    end
  end
  assign DSACK = dsack_r & {2{~nDS}};
  assign BUSY = (state != BT_IDLE);
  assign ACT_CH = ch;
  bus_watchdog #(.BERR_CYCLES(BERR_CYCLES)) u_wd (
    .CPU_CLK(CPU_CLK),
    .RESET(RESET),
    .nAS(nAS),
    .BERR(BERR)
  );
endmodule

// File: tb/tb_bus_term.sv
// tb_bus_term: transaction-level checks of bus_term timing, priority, abort and watchdog
module tb_bus_term;
  localparam int BC = 64;
  logic CPU_CLK = 1'b0;
  logic RESET, nAS, nDS;
  logic [4:0] nSEL, nWAIT;
  logic [1:0] DSACK;
  logic BERR, BUSY;
  logic [2:0] ACT_CH;
  int checks = 0, failures = 0, streak = 0;
  int W[5] = '{1, 0, 5, 2, 3};
  int PS[5] = '{2, 3, 1, 2, 0};
  typedef struct {
    logic [4:0] mask;
    int d, s, l, g, win, ps, ack;
  } vec_t;
  vec_t tbl[11];
  always #5 CPU_CLK = ~CPU_CLK;
  bus_term #(
    .NCHAN(5), .WS_W(4),
    .WAITS({4'd3, 4'd2, 4'd5, 4'd0, 4'd1}),
    .PORTSZ({2'b00, 2'b10, 2'b01, 2'b11, 2'b10}),
    .BERR_CYCLES(BC)
  ) dut (
    .CPU_CLK(CPU_CLK), .RESET(RESET), .nAS(nAS), .nDS(nDS), .nSEL(nSEL),
    .nWAIT(nWAIT), .DSACK(DSACK), .BERR(BERR), .BUSY(BUSY), .ACT_CH(ACT_CH)
  );
  task automatic chk(input string name, input int j, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", name, j, act, exp);
    end
  endtask
  function automatic int win_of(input logic [4:0] m);
    for (int i = 0; i < 5; i++) if (m[i] && PS[i] != 0) return i;
    return -1;
  endfunction
  // one bus cycle: /AS low for l edges, /DS low from edge d, winner stalled s edges by nWAIT
  task automatic run_txn(input logic [4:0] m, input int d, s, l, g, win, ps, ack);
    bit busy;
    for (int j = 0; j < l + g; j++) begin
      nAS = (j < l) ? 1'b0 : 1'b1;
      nDS = (j >= d && j < l) ? 1'b0 : 1'b1;
      nSEL = (j >= l) ? 5'h1f : (j == 0 || win < 0) ? ~m : 5'($urandom);
      nWAIT = 5'($urandom);
      if (win >= 0) nWAIT[win] = (j <= W[win] + s) ? 1'b0 : 1'b1;
      @(posedge CPU_CLK);
      streak = nAS ? 0 : streak + 1;
      #1;
      busy = (win >= 0 && j < l);
      chk("BUSY", j, int'(BUSY), int'(busy));
      chk("ACT_CH", j, int'(ACT_CH), busy ? win : 0);
      chk("DSACK", j, int'(DSACK), (busy && j >= ack && !nDS) ? ps : 0);
      chk("BERR", j, int'(BERR), int'(streak >= BC));
      @(negedge CPU_CLK);
    end
  endtask
  initial begin
    tbl[0]  = '{5'b00001, 1, 0, 5, 1, 0, 2, 2};
    tbl[1]  = '{5'b00100, 1, 0, 9, 1, 2, 1, 6};
    tbl[2]  = '{5'b01010, 1, 0, 4, 1, 1, 3, 1};
    tbl[3]  = '{5'b00001, 1, 10, 16, 1, 0, 2, 12};
    tbl[4]  = '{5'b10000, 1, 0, 3, 2, -1, 0, 0};
    tbl[5]  = '{5'b00100, 1, 0, 4, 1, 2, 1, 6};
    tbl[6]  = '{5'b01000, 4, 0, 7, 1, 3, 2, 3};
    tbl[7]  = '{5'b11001, 2, 1, 6, 3, 0, 2, 3};
    tbl[8]  = '{5'b00000, 1, 0, 66, 1, -1, 0, 0};
    tbl[9]  = '{5'b10000, 1, 0, 66, 1, -1, 0, 0};
    tbl[10] = '{5'b00001, 1, 70, 75, 1, 0, 2, 72};
    RESET = 1'b1; nAS = 1'b1; nDS = 1'b1; nSEL = 5'h1f; nWAIT = 5'h1f;
    repeat (2) @(posedge CPU_CLK);
    #1;
    chk("rst_DSACK", 0, int'(DSACK), 0);
    chk("rst_BERR", 0, int'(BERR), 0);
    chk("rst_BUSY", 0, int'(BUSY), 0);
    chk("rst_ACT_CH", 0, int'(ACT_CH), 0);
    @(negedge CPU_CLK);
    RESET = 1'b0;
    for (int t = 0; t < 11; t++)
      run_txn(tbl[t].mask, tbl[t].d, tbl[t].s, tbl[t].l, tbl[t].g, tbl[t].win, tbl[t].ps, tbl[t].ack);
    nAS = 1'b0; nDS = 1'b0; nSEL = ~5'b00010; nWAIT = 5'h1f;
    repeat (2) @(posedge CPU_CLK);
    #1;
    chk("pre_rst_DSACK", 1, int'(DSACK), 3);
    chk("pre_rst_BUSY", 1, int'(BUSY), 1);
    @(negedge CPU_CLK);
    RESET = 1'b1;
    @(posedge CPU_CLK);
    #1;
    streak = 0;
    chk("mid_rst_DSACK", 2, int'(DSACK), 0);
    chk("mid_rst_BUSY", 2, int'(BUSY), 0);
    chk("mid_rst_ACT_CH", 2, int'(ACT_CH), 0);
    @(negedge CPU_CLK);
    RESET = 1'b0; nAS = 1'b1; nDS = 1'b1; nSEL = 5'h1f;
    @(posedge CPU_CLK);
    @(negedge CPU_CLK);
    run_txn(5'b00010, 1, 0, 4, 1, 1, 3, 1);
    for (int n = 0; n < 40; n++) begin
      logic [4:0] m;
      int d, s, l, g, w;
      bit long_c;
      m = 5'($urandom);
      long_c = ($urandom_range(0, 9) == 0);
      l = long_c ? $urandom_range(60, 80) : $urandom_range(1, 14);
      s = long_c ? $urandom_range(0, 70) : $urandom_range(0, 4);
      d = $urandom_range(1, 4);
      g = $urandom_range(1, 3);
      w = win_of(m);
      run_txn(m, d, s, l, g, w, (w < 0) ? 0 : PS[w], (w < 0) ? 0 : 1 + W[w] + s);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
